// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Measures the period and high time of an asynchronous divided clock in
//   units of the system clock. It compares the measured period with the
//   programmed divide ratio and flags a missing edge with a sticky error bit.
//
// Ports
//   clk          system clock; all flops are clocked on its rising edge
//   rst_n        asynchronous active-low reset
//   div_clk      divided clock under test (asynchronous to clk)
//   enable       1 = measure, 0 = idle
//   expected_n   divide ratio programmed into the divider (unsigned)
//   period       last measured div_clk period, in clk cycles
//   high_time    clk cycles div_clk was high during the last period
//   meas_valid   one-cycle pulse when period/high_time update
//   match        last period equals expected_n (only when expected_n >= 2)
//   timeout_err  sticky missing-edge flag; cleared while enable = 0
//   meas_count   number of completed measurements (wraps)
module clk_period_meter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        div_clk,
    input  logic        enable,
    input  logic [31:0] expected_n,
    output logic [31:0] period,
    output logic [31:0] high_time,
    output logic        meas_valid,
    output logic        match,
    output logic        timeout_err,
    output logic [15:0] meas_count
);

    typedef enum logic [1:0] {StIdle, StArm, StMeas} state_e;

    localparam logic [31:0] CntMax = 32'hFFFF_FFFF;

    state_e state_q, state_d;

    logic        sync1_q, sync2_q, prev_q;
    logic        rise;
    logic        timeout;
    logic [31:0] cnt_q, hcnt_q;
    logic [31:0] period_q, high_time_q;
    logic        meas_valid_q, match_q, timeout_err_q;
    logic [15:0] meas_count_q;

    // Control strobes decoded from the FSM
    logic load_cnt, record, inc_cnt, set_timeout;

    // ------------------------------------------------------------------
    // Synchronizer and edge detector (kept running even when idle)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= div_clk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;

    // Limit is 2*expected_n at 33 bits so a large ratio cannot overflow.
    always_comb begin
        timeout = 1'b0;
        if (state_q == StMeas && enable && !rise && expected_n != 32'd0) begin
            timeout = {1'b0, cnt_q} > {expected_n, 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StArm;
                StArm:   if (rise) state_d = StMeas;
                StMeas:  if (timeout) state_d = StArm;
                default: state_d = StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        load_cnt    = 1'b0;
        record      = 1'b0;
        inc_cnt     = 1'b0;
        set_timeout = 1'b0;
        if (enable) begin
            unique case (state_q)
                StArm: begin
                    load_cnt = rise;
                end
                StMeas: begin
                    // A rise in the same cycle as a timeout wins.
                    load_cnt    = rise;
                    record      = rise;
                    set_timeout = timeout;
                    inc_cnt     = !rise && !timeout;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 32'd0;
            hcnt_q <= 32'd0;
        end else if (!enable) begin
            cnt_q  <= 32'd0;
            hcnt_q <= 32'd0;
        end else if (load_cnt) begin
            // The rise cycle itself is the first cycle of the new period.
            cnt_q  <= 32'd1;
            hcnt_q <= 32'd1;
        end else if (inc_cnt) begin
            if (cnt_q != CntMax) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (sync2_q && hcnt_q != CntMax) begin
                hcnt_q <= hcnt_q + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q      <= 32'd0;
            high_time_q   <= 32'd0;
            meas_valid_q  <= 1'b0;
            match_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            meas_count_q  <= 16'd0;
        end else begin
            meas_valid_q <= record;
            if (record) begin
                period_q     <= cnt_q;
                high_time_q  <= hcnt_q;
                match_q      <= (cnt_q == expected_n) && (expected_n >= 32'd2);
                meas_count_q <= meas_count_q + 16'd1;
            end
            if (!enable) begin
                timeout_err_q <= 1'b0;
            end else if (set_timeout) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign period      = period_q;
    assign high_time   = high_time_q;
    assign meas_valid  = meas_valid_q;
    assign match       = match_q;
    assign timeout_err = timeout_err_q;
    assign meas_count  = meas_count_q;

endmodule

// File: tb/tb_clk_period_meter.sv
module tb_clk_period_meter;

    logic        clk;
    logic        rst_n;
    logic        div_clk;
    logic        enable;
    logic [31:0] expected_n;
    logic [31:0] period;
    logic [31:0] high_time;
    logic        meas_valid;
    logic        match;
    logic        timeout_err;
    logic [15:0] meas_count;

    int errors = 0;
    int checks = 0;
    bit div_run = 0;
    logic [15:0] exp_mc = 16'd0;

    clk_period_meter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_clk     (div_clk),
        .enable      (enable),
        .expected_n  (expected_n),
        .period      (period),
        .high_time   (high_time),
        .meas_valid  (meas_valid),
        .match       (match),
        .timeout_err (timeout_err),
        .meas_count  (meas_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // div_clk: 70 ns period, 30 ns high; edges land 3 ns before a clk rise.
    initial begin
        div_clk = 1'b0;
        #2;
        forever begin
            if (div_run) begin
                div_clk = 1'b1;
                #30;
                div_clk = 1'b0;
                #40;
            end else begin
                div_clk = 1'b0;
                #10;
            end
        end
    end

    task automatic wait_valid(input int budget, output bit seen, output int n);
        seen = 1'b0;
        n = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (meas_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        expected_n = 32'd7;
        div_run = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({period, high_time, meas_valid, match, timeout_err, meas_count} !== '0) begin
            $display("FAIL reset_outputs: got p=%0d h=%0d v=%b m=%b t=%b c=%0d required all 0",
                     period, high_time, meas_valid, match, timeout_err, meas_count);
            errors++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({meas_valid, timeout_err, meas_count} !== '0) begin
            $display("FAIL reset_release: got v=%b t=%b c=%0d required 0", meas_valid,
                     timeout_err, meas_count);
            errors++;
        end
    endtask

    task automatic test_match();
        bit seen;
        int n;
        expected_n = 32'd7;
        enable = 1'b1;
        div_run = 1'b1;
        wait_valid(40, seen, n);
        exp_mc = 16'd1;
        checks++;
        if (!seen) begin
            $display("FAIL first_valid: no meas_valid within 40 cycles");
            errors++;
        end
        checks++;
        if (period !== 32'd7) begin
            $display("FAIL match_period: got %0d required 7", period);
            errors++;
        end
        checks++;
        if (high_time !== 32'd3) begin
            $display("FAIL match_high: got %0d required 3", high_time);
            errors++;
        end
        checks++;
        if (match !== 1'b1) begin
            $display("FAIL match_flag: got %b required 1", match);
            errors++;
        end
        checks++;
        if (meas_count !== exp_mc) begin
            $display("FAIL match_count1: got %0d required %0d", meas_count, exp_mc);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (meas_valid !== 1'b0) begin
            $display("FAIL valid_width: got %b required 0", meas_valid);
            errors++;
        end
        wait_valid(20, seen, n);
        exp_mc++;
        checks++;
        if (!seen || n != 6) begin
            $display("FAIL valid_spacing: got seen=%b after %0d cycles required 7", seen, n + 1);
            errors++;
        end
        checks++;
        if (meas_count !== exp_mc) begin
            $display("FAIL match_count2: got %0d required %0d", meas_count, exp_mc);
            errors++;
        end
    endtask

    task automatic test_mismatch();
        bit seen;
        int n;
        expected_n = 32'd5;
        repeat (2) begin
            wait_valid(20, seen, n);
            exp_mc++;
            checks++;
            if (!seen) begin
                $display("FAIL mismatch_valid: no meas_valid within 20 cycles");
                errors++;
            end
            checks++;
            if (period !== 32'd7 || match !== 1'b0) begin
                $display("FAIL mismatch_result: got p=%0d m=%b required p=7 m=0", period, match);
                errors++;
            end
            checks++;
            if (timeout_err !== 1'b0) begin
                $display("FAIL mismatch_timeout: got %b required 0", timeout_err);
                errors++;
            end
        end
        checks++;
        if (meas_count !== exp_mc) begin
            $display("FAIL mismatch_count: got %0d required %0d", meas_count, exp_mc);
            errors++;
        end
    endtask

    task automatic test_timeout();
        bit seen;
        int n;
        bit early;
        expected_n = 32'd7;
        wait_valid(20, seen, n);
        exp_mc++;
        div_run = 1'b0;
        checks++;
        if (!seen || match !== 1'b1) begin
            $display("FAIL pre_timeout_valid: got seen=%b m=%b required 1 1", seen, match);
            errors++;
        end
        // cnt=1 at the recording edge; reaches 15 after 14 more edges.
        repeat (14) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            $display("FAIL timeout_early: got %b at cnt=15 cycle, required 0", timeout_err);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1) begin
            $display("FAIL timeout_set: got %b required 1", timeout_err);
            errors++;
        end
        checks++;
        if (period !== 32'd7 || high_time !== 32'd3 || match !== 1'b1) begin
            $display("FAIL timeout_hold: got p=%0d h=%0d m=%b required 7 3 1", period,
                     high_time, match);
            errors++;
        end
        repeat (5) @(negedge clk);
        div_run = 1'b1;
        early = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (meas_valid === 1'b1) early = 1'b1;
        end
        checks++;
        if (early) begin
            $display("FAIL restart_two_rises: got meas_valid after one rise required 0");
            errors++;
        end
        wait_valid(10, seen, n);
        exp_mc++;
        checks++;
        if (!seen || period !== 32'd7) begin
            $display("FAIL restart_valid: got seen=%b p=%0d required 1 7", seen, period);
            errors++;
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            $display("FAIL timeout_sticky: got %b required 1", timeout_err);
            errors++;
        end
        checks++;
        if (meas_count !== exp_mc) begin
            $display("FAIL restart_count: got %0d required %0d", meas_count, exp_mc);
            errors++;
        end
    endtask

    task automatic test_enable();
        bit seen;
        int n;
        bit any_valid;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            $display("FAIL disable_clear: got timeout_err=%b required 0", timeout_err);
            errors++;
        end
        any_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (meas_valid === 1'b1) any_valid = 1'b1;
        end
        checks++;
        if (any_valid) begin
            $display("FAIL idle_valid: got meas_valid=1 while idle required 0");
            errors++;
        end
        checks++;
        if (period !== 32'd7 || match !== 1'b1 || meas_count !== exp_mc) begin
            $display("FAIL idle_hold: got p=%0d m=%b c=%0d required 7 1 %0d", period, match,
                     meas_count, exp_mc);
            errors++;
        end
        enable = 1'b1;
        wait_valid(30, seen, n);
        exp_mc++;
        checks++;
        if (!seen || period !== 32'd7 || high_time !== 32'd3) begin
            $display("FAIL reenable_valid: got seen=%b p=%0d h=%0d required 1 7 3", seen,
                     period, high_time);
            errors++;
        end
        checks++;
        if (meas_count !== exp_mc) begin
            $display("FAIL reenable_count: got %0d required %0d", meas_count, exp_mc);
            errors++;
        end
        // expected_n = 0: no timeout however long div_clk stays low.
        expected_n = 32'd0;
        wait_valid(20, seen, n);
        exp_mc++;
        div_run = 1'b0;
        checks++;
        if (!seen || match !== 1'b0) begin
            $display("FAIL zero_n_match: got seen=%b m=%b required 1 0", seen, match);
            errors++;
        end
        repeat (40) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            $display("FAIL zero_n_timeout: got %b required 0", timeout_err);
            errors++;
        end
        // New ratio applies at the next comparison: cnt is already past 14.
        expected_n = 32'd7;
        repeat (2) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1) begin
            $display("FAIL n_change_timeout: got %b required 1", timeout_err);
            errors++;
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        int n;
        div_run = 1'b1;
        wait_valid(30, seen, n);
        exp_mc++;
        checks++;
        if (!seen) begin
            $display("FAIL pre_reset_valid: no meas_valid within 30 cycles");
            errors++;
        end
        // div_clk is low here, so releasing reset sees no false edge.
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({period, high_time, meas_valid, match, timeout_err, meas_count} !== '0) begin
            $display("FAIL async_reset: got p=%0d h=%0d v=%b m=%b t=%b c=%0d required all 0",
                     period, high_time, meas_valid, match, timeout_err, meas_count);
            errors++;
        end
        #1 rst_n = 1'b1;
        exp_mc = 16'd0;
        wait_valid(40, seen, n);
        exp_mc++;
        checks++;
        if (!seen || period !== 32'd7 || meas_count !== exp_mc) begin
            $display("FAIL post_reset_meas: got seen=%b p=%0d c=%0d required 1 7 %0d", seen,
                     period, meas_count, exp_mc);
            errors++;
        end
    endtask

    task automatic test_wrap();
        bit seen;
        int n;
        wait_valid(20, seen, n);
        force dut.meas_count_q = 16'hFFFE;
        #1 release dut.meas_count_q;
        wait_valid(20, seen, n);
        checks++;
        if (!seen || meas_count !== 16'hFFFF) begin
            $display("FAIL wrap_ffff: got seen=%b c=%0h required 1 ffff", seen, meas_count);
            errors++;
        end
        wait_valid(20, seen, n);
        checks++;
        if (!seen || meas_count !== 16'h0000) begin
            $display("FAIL wrap_zero: got seen=%b c=%0h required 1 0", seen, meas_count);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_timeout();
        test_enable();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
